// File: rtl/regfile_writeback_stage.sv
// regfile_writeback_stage: MEM/WB register with load extraction, x0/misalign write suppression and retire counter
module regfile_writeback_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  input  logic             mem_stall,
  input  logic             flush,
  input  logic             mem_regwrite,
  input  logic [1:0]       mem_wbsel,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_pc,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_regwrite,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retired
);
  logic [2:0]       w_off;
  logic [XLEN-1:0]  w_sh, w_load, w_sel;
  logic             w_mis, w_take, w_sx;
  logic             r_valid, r_regwrite, r_err;
  logic [4:0]       r_rd;
  logic [XLEN-1:0]  r_data;
  logic [CNT_W-1:0] r_retired;
  assign w_off  = mem_alu_result[2:0];
  assign w_sh   = mem_rdata >> {w_off, 3'b000};
  assign w_sx   = ~mem_funct3[2];
  assign w_take = mem_valid & ~mem_stall & ~flush;
  always_comb begin
    w_load = mem_funct3[1:0] == 2'b00 ? {{(XLEN-8){w_sx & w_sh[7]}}, w_sh[7:0]} :
             mem_funct3[1:0] == 2'b01 ? {{(XLEN-16){w_sx & w_sh[15]}}, w_sh[15:0]} :
             mem_funct3[1:0] == 2'b10 ? {{(XLEN-32){w_sx & w_sh[31]}}, w_sh[31:0]} : w_sh;
    w_mis  = mem_wbsel == 2'b01 &
             (mem_funct3 == 3'b111 | (mem_funct3[1:0] == 2'b01 & w_off[0]) |
              (mem_funct3[1:0] == 2'b10 & |w_off[1:0]) | (mem_funct3 == 3'b011 & |w_off));
    w_sel  = mem_wbsel == 2'b01 ? w_load :
             mem_wbsel == 2'b10 ? mem_pc + XLEN'(4) : mem_alu_result;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_err      <= 1'b0;
      r_rd       <= '0;
      r_data     <= '0;
      r_retired  <= '0;
    end else begin
      r_valid    <= w_take;
      r_regwrite <= w_take & mem_regwrite & ~w_mis;
      r_err      <= w_take & w_mis;
      if (w_take) begin
        r_rd   <= mem_rd;
        r_data <= w_sel;
      end
      if (r_valid) r_retired <= r_retired + CNT_W'(1);
    end
  end
  assign wb_rd        = r_rd;
  assign wb_data      = r_data;
  assign wb_regwrite  = r_valid & r_regwrite & |r_rd;
  assign fwd_valid    = wb_regwrite;
  assign fwd_rd       = wb_rd;
  assign fwd_data     = wb_data;
  assign misalign_err = r_err;
  assign retired      = r_retired;
endmodule

// File: tb/tb_regfile_writeback_stage.sv
// tb_regfile_writeback_stage: directed vector table plus reset and stall/flush sequences
module tb_regfile_writeback_stage;
  logic        clk = 1'b0;
  logic        reset, mem_valid, mem_stall, flush, mem_regwrite;
  logic [1:0]  mem_wbsel;
  logic [4:0]  mem_rd;
  logic [63:0] mem_alu_result, mem_pc, mem_rdata;
  logic [2:0]  mem_funct3;
  logic [4:0]  wb_rd, fwd_rd;
  logic [63:0] wb_data, fwd_data;
  logic        wb_regwrite, fwd_valid, misalign_err;
  logic [31:0] retired;
  int checks = 0;
  int failures = 0;
  int exp_ret = 0;
  bit pend = 0;
  typedef struct {
    bit v, st, fl, rw;
    logic [1:0]  wbsel;
    logic [4:0]  rd;
    logic [63:0] alu, pc;
    logic [2:0]  f3;
    logic [63:0] rdata;
    bit e_we, e_err;
    logic [63:0] e_data;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  regfile_writeback_stage dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_stall(mem_stall), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_wbsel(mem_wbsel), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .mem_pc(mem_pc), .mem_funct3(mem_funct3),
    .mem_rdata(mem_rdata), .wb_rd(wb_rd), .wb_data(wb_data), .wb_regwrite(wb_regwrite),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .misalign_err(misalign_err), .retired(retired)
  );
  function automatic vec_t mk(bit v, bit st, bit fl, bit rw, logic [1:0] wbsel, logic [4:0] rd,
                              logic [63:0] alu, logic [63:0] pc, logic [2:0] f3, logic [63:0] rdata,
                              bit e_we, bit e_err, logic [63:0] e_data);
    vec_t x;
    x.v = v; x.st = st; x.fl = fl; x.rw = rw; x.wbsel = wbsel; x.rd = rd; x.alu = alu; x.pc = pc;
    x.f3 = f3; x.rdata = rdata; x.e_we = e_we; x.e_err = e_err; x.e_data = e_data;
    return x;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    mem_valid = x.v; mem_stall = x.st; flush = x.fl; mem_regwrite = x.rw; mem_wbsel = x.wbsel;
    mem_rd = x.rd; mem_alu_result = x.alu; mem_pc = x.pc; mem_funct3 = x.f3; mem_rdata = x.rdata;
  endtask
  task automatic tick(input bit take);
    if (pend) exp_ret++;
    pend = take;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string name, input vec_t x);
    chk({name, " we"}, 64'(wb_regwrite), 64'(x.e_we));
    chk({name, " fwd_valid"}, 64'(fwd_valid), 64'(x.e_we));
    chk({name, " err"}, 64'(misalign_err), 64'(x.e_err));
    chk({name, " retired"}, 64'(retired), 64'(exp_ret));
    if (x.e_we) begin
      chk({name, " rd"}, 64'(wb_rd), 64'(x.rd));
      chk({name, " data"}, wb_data, x.e_data);
      chk({name, " fwd_rd"}, 64'(fwd_rd), 64'(x.rd));
      chk({name, " fwd_data"}, fwd_data, x.e_data);
    end
  endtask
  task automatic run(input string name, input vec_t x);
    drive(x);
    tick(x.v & ~x.st & ~x.fl);
    chk_out(name, x);
  endtask
  initial begin
    vec_t a, b;
    vecs.push_back(mk(1,0,0,1,2'b00,5, 64'h1234,0,0,0, 1,0,64'h1234));
    vecs.push_back(mk(1,0,0,1,2'b01,7, 64'h3,0,3'b000,64'h0000_0000_80FF_0000, 1,0,64'hFFFF_FFFF_FFFF_FF80));
    vecs.push_back(mk(1,0,0,1,2'b01,7, 64'h3,0,3'b100,64'h0000_0000_80FF_0000, 1,0,64'h80));
    vecs.push_back(mk(1,0,0,1,2'b01,7, 64'h2,0,3'b010,64'h1111_2222_3333_4444, 0,1,0));
    vecs.push_back(mk(1,0,0,1,2'b01,8, 64'h6,0,3'b101,64'hBEEF_0000_0000_0000, 1,0,64'hBEEF));
    vecs.push_back(mk(1,0,0,1,2'b10,1, 64'h0,64'hFFFF_FFFF_FFFF_FFFC,0,0, 1,0,64'h0));
    vecs.push_back(mk(1,0,0,1,2'b10,0, 64'h0,64'hFFFF_FFFF_FFFF_FFFC,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,1,2'b10,2, 64'h0,64'h0000_0000_0000_1000,0,0, 1,0,64'h1004));
    vecs.push_back(mk(1,0,0,1,2'b01,9, 64'h1002,0,3'b001,64'h0000_0000_8001_0000, 1,0,64'hFFFF_FFFF_FFFF_8001));
    vecs.push_back(mk(1,0,0,1,2'b01,9, 64'h4,0,3'b010,64'h8765_4321_0000_0000, 1,0,64'hFFFF_FFFF_8765_4321));
    vecs.push_back(mk(1,0,0,1,2'b01,9, 64'h4,0,3'b110,64'h8765_4321_0000_0000, 1,0,64'h8765_4321));
    vecs.push_back(mk(1,0,0,1,2'b01,10,64'h8,0,3'b011,64'h0123_4567_89AB_CDEF, 1,0,64'h0123_4567_89AB_CDEF));
    vecs.push_back(mk(1,0,0,1,2'b01,10,64'h4,0,3'b011,64'h0123_4567_89AB_CDEF, 0,1,0));
    vecs.push_back(mk(1,0,0,1,2'b01,10,64'h0,0,3'b111,64'h0123_4567_89AB_CDEF, 0,1,0));
    vecs.push_back(mk(1,0,0,1,2'b01,11,64'h1,0,3'b001,64'hFFFF, 0,1,0));
    vecs.push_back(mk(1,0,0,1,2'b11,12,64'h55,64'h100,0,0, 1,0,64'h55));
    vecs.push_back(mk(0,0,0,1,2'b00,13,64'h77,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,2'b00,13,64'h77,0,0,0, 0,0,0));
    vecs.push_back(mk(1,1,0,1,2'b00,14,64'h88,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,1,1,2'b01,14,64'h1,0,3'b011,0, 0,0,0));
    vecs.push_back(mk(1,0,0,1,2'b00,15,64'hCAFE,0,0,0, 1,0,64'hCAFE));
    reset = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset we", 64'(wb_regwrite), 0);
    chk("reset err", 64'(misalign_err), 0);
    chk("reset retired", 64'(retired), 0);
    chk("reset rd", 64'(wb_rd), 0);
    chk("reset data", wb_data, 0);
    reset = 1'b0;
    foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i]);
    a = mk(1,0,0,1,2'b00,3,64'hA,0,0,0, 1,0,64'hA);
    run("b2b first", a);
    b = mk(1,1,1,1,2'b00,4,64'hB,0,0,0, 0,0,0);
    run("b2b squashed", b);
    b = mk(1,0,0,1,2'b00,5,64'hC,0,0,0, 1,0,64'hC);
    run("b2b third", b);
    a = mk(1,0,0,1,2'b01,6,64'h2,0,3'b010,0, 0,0,0);
    drive(a);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_ret = 0;
    pend = 0;
    chk("midreset we", 64'(wb_regwrite), 0);
    chk("midreset err", 64'(misalign_err), 0);
    chk("midreset retired", 64'(retired), 0);
    reset = 1'b0;
    run("post reset", mk(1,0,0,1,2'b00,9,64'h99,0,0,0, 1,0,64'h99));
    run("post reset bubble", mk(0,0,0,0,2'b00,0,0,0,0,0, 0,0,0));
    chk("post reset count", 64'(retired), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
